// File: rtl/spike_acc_pkg.sv
// ============================================================================
// Module   : spike_acc_pkg
// Brief    : Width constants, saturation bounds and weight sign-extension
//            shared by the spike accumulator bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spike_acc_pkg;

    localparam int NUM_NEU = 64;
    localparam int W_W     = 4;
    localparam int ACC_W   = 12;
    localparam int SEL_W   = 6;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Widen a two's-complement weight lane to accumulator width.
    function automatic logic [ACC_W-1:0] sext_w(input logic [W_W-1:0] w);
        return {{(ACC_W-W_W){w[W_W-1]}}, w};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spike_accumulator_bank_if.sv
// ============================================================================
// Module   : spike_accumulator_bank_if
// Brief    : Control, spike/weight and shadow-readout signals of the bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spike_accumulator_bank_if;
    import spike_acc_pkg::*;

    logic                     cntrl_ac_reset;
    logic                     cntrl_ac_oen;
    logic                     spk_valid;
    logic                     spk_in;
    logic [NUM_NEU*W_W-1:0]   w_in;
    logic [SEL_W-1:0]         ac_sel;
    logic [ACC_W-1:0]         ac_out;
    logic                     ac_snap_valid;

    modport master (
        output cntrl_ac_reset, cntrl_ac_oen, spk_valid, spk_in, w_in, ac_sel,
        input  ac_out, ac_snap_valid
    );

    modport slave (
        input  cntrl_ac_reset, cntrl_ac_oen, spk_valid, spk_in, w_in, ac_sel,
        output ac_out, ac_snap_valid
    );

endinterface

`default_nettype wire

// File: rtl/spike_acc_lane.sv
// ============================================================================
// Module   : spike_acc_lane
// Brief    : One live accumulator plus its shadow entry. Overflow clamps when
//            SPIKE_ACC_SATURATE_EN is defined, otherwise wraps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_acc_lane
    import spike_acc_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clr,
    input  wire logic             snap,
    input  wire logic             add_en,
    input  wire logic [W_W-1:0]   w,
    output logic      [ACC_W-1:0] shadow
);

    logic [ACC_W-1:0] pending;
    logic [ACC_W-1:0] next_val;
    logic [ACC_W-1:0] acc_d,    acc_q;
    logic [ACC_W-1:0] shadow_d, shadow_q;
`ifdef SPIKE_ACC_SATURATE_EN
    logic [ACC_W:0]   sum;
`endif

    always_comb begin
        pending  = add_en ? sext_w(w) : '0;
`ifdef SPIKE_ACC_SATURATE_EN
        // One guard bit: overflow shows up as disagreement of the top two bits.
        sum      = {acc_q[ACC_W-1], acc_q} + {pending[ACC_W-1], pending};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            next_val = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            next_val = sum[ACC_W-1:0];
        end
`else
        next_val = acc_q + pending;
`endif
        // The snapshot captures the in-flight contribution even when the
        // live bank is cleared in the same cycle.
        acc_d    = clr  ? '0       : next_val;
        shadow_d = snap ? next_val : shadow_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            shadow_q <= '0;
        end else begin
            acc_q    <= acc_d;
            shadow_q <= shadow_d;
        end
    end

    assign shadow = shadow_q;

endmodule

`default_nettype wire

// File: rtl/spike_accumulator_bank.sv
// ============================================================================
// Module   : spike_accumulator_bank
// Brief    : Stage-1 input register, NUM_NEU accumulator lanes and registered
//            shadow readout mux. Saturation selected by SPIKE_ACC_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_accumulator_bank
    import spike_acc_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset,
    spike_accumulator_bank_if.slave bus
);

    logic                   spk_d,        spk_q;
    logic [NUM_NEU*W_W-1:0] w_d,          w_q;
    logic [ACC_W-1:0]       ac_out_d,     ac_out_q;
    logic                   snap_valid_d, snap_valid_q;
    logic [ACC_W-1:0]       lane_shadow [NUM_NEU];

    always_comb begin
        spk_d        = bus.spk_in & bus.spk_valid;
        w_d          = bus.w_in;
        // Reads the pre-snapshot shadow value; a same-cycle snapshot shows next cycle.
        ac_out_d     = lane_shadow[bus.ac_sel];
        snap_valid_d = snap_valid_q | bus.cntrl_ac_oen;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spk_q        <= 1'b0;
            w_q          <= '0;
            ac_out_q     <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            spk_q        <= spk_d;
            w_q          <= w_d;
            ac_out_q     <= ac_out_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_NEU; i++) begin : g_lane
            spike_acc_lane u_lane (
                .clk    (clk),
                .reset  (reset),
                .clr    (bus.cntrl_ac_reset),
                .snap   (bus.cntrl_ac_oen),
                .add_en (spk_q),
                .w      (w_q[i*W_W +: W_W]),
                .shadow (lane_shadow[i])
            );
        end
    endgenerate

    assign bus.ac_out        = ac_out_q;
    assign bus.ac_snap_valid = snap_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_spike_accumulator_bank.sv
// ============================================================================
// Module   : tb_spike_accumulator_bank
// Brief    : Directed and randomized checks of the accumulator bank against an
//            integer reference model. Honours SPIKE_ACC_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spike_accumulator_bank;
    import spike_acc_pkg::*;

    logic clk;
    logic reset;
    spike_accumulator_bank_if bus_if ();

    spike_accumulator_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference state: plain integers per neuron.
    int m_acc    [NUM_NEU];
    int m_shadow [NUM_NEU];
    int m_w      [NUM_NEU];
    bit m_spk;
    int m_out;
    int m_valid;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fit(input int s);
        int v;
`ifdef SPIKE_ACC_SATURATE_EN
        if (s > (1 << (ACC_W-1)) - 1) return (1 << (ACC_W-1)) - 1;
        if (s < -(1 << (ACC_W-1)))    return -(1 << (ACC_W-1));
        return s;
`else
        v = s & ((1 << ACC_W) - 1);
        if (v >= (1 << (ACC_W-1))) v = v - (1 << ACC_W);
        return v;
`endif
    endfunction

    function automatic logic [NUM_NEU*W_W-1:0] all_w(input int v);
        logic [NUM_NEU*W_W-1:0] r;
        for (int i = 0; i < NUM_NEU; i++) r[i*W_W +: W_W] = v[W_W-1:0];
        return r;
    endfunction

    function automatic logic [NUM_NEU*W_W-1:0] one_w(input int lane, input int v);
        logic [NUM_NEU*W_W-1:0] r;
        r = '0;
        r[lane*W_W +: W_W] = v[W_W-1:0];
        return r;
    endfunction

    task automatic model_step();
        int nv;
        logic signed [W_W-1:0] t;
        if (reset) begin
            for (int i = 0; i < NUM_NEU; i++) begin
                m_acc[i] = 0; m_shadow[i] = 0; m_w[i] = 0;
            end
            m_spk = 0; m_out = 0; m_valid = 0;
        end else begin
            m_out = m_shadow[bus_if.ac_sel];
            for (int i = 0; i < NUM_NEU; i++) begin
                nv = fit(m_acc[i] + (m_spk ? m_w[i] : 0));
                if (bus_if.cntrl_ac_oen) m_shadow[i] = nv;
                m_acc[i] = bus_if.cntrl_ac_reset ? 0 : nv;
            end
            if (bus_if.cntrl_ac_oen) m_valid = 1;
            m_spk = bus_if.spk_in && bus_if.spk_valid;
            for (int i = 0; i < NUM_NEU; i++) begin
                t = bus_if.w_in[i*W_W +: W_W];
                m_w[i] = int'(t);
            end
        end
    endtask

    // Advance one clock, updating the model with the inputs present at the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("ac_out", int'($signed(bus_if.ac_out)), m_out);
        check("snap_valid", int'(bus_if.ac_snap_valid), m_valid);
    endtask

    task automatic idle_inputs();
        bus_if.cntrl_ac_reset = 1'b0;
        bus_if.cntrl_ac_oen   = 1'b0;
        bus_if.spk_in         = 1'b0;
        bus_if.spk_valid      = 1'b0;
    endtask

    task automatic handoff(input bit clr);
        idle_inputs();
        bus_if.cntrl_ac_oen   = 1'b1;
        bus_if.cntrl_ac_reset = clr;
        cycle();
        idle_inputs();
    endtask

    task automatic spikes(input int n);
        bus_if.spk_in    = 1'b1;
        bus_if.spk_valid = 1'b1;
        repeat (n) cycle();
        idle_inputs();
    endtask

    task automatic read_lane(input int sel, input int exp, input string tag);
        idle_inputs();
        bus_if.ac_sel = sel[SEL_W-1:0];
        cycle();
        check(tag, int'($signed(bus_if.ac_out)), exp);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        idle_inputs();
        bus_if.w_in   = '0;
        bus_if.ac_sel = '0;
        repeat (2) cycle();
        check("reset_out", int'($signed(bus_if.ac_out)), 0);
        check("reset_valid", int'(bus_if.ac_snap_valid), 0);
        reset = 1'b0;
        cycle();

        // Basic accumulation: three spikes of +3 everywhere.
        bus_if.w_in = all_w(3);
        spikes(3);
        cycle();
        handoff(1'b1);
        for (int i = 0; i < NUM_NEU; i++) read_lane(i, 9, "basic");
        check("basic_valid", int'(bus_if.ac_snap_valid), 1);

        // Gated inputs on lane 5.
        bus_if.w_in = one_w(5, -2);
        for (int k = 0; k < 4; k++) begin
            bus_if.spk_in    = (k % 2 == 0);
            bus_if.spk_valid = 1'b1;
            cycle();
        end
        bus_if.spk_in    = 1'b1;
        bus_if.spk_valid = 1'b0;
        repeat (2) cycle();
        idle_inputs();
        cycle();
        handoff(1'b1);
        read_lane(5, -4, "gated_l5");
        read_lane(4, 0, "gated_l4");

        // In-flight snapshot: the last spike is still in stage 1 at hand-off.
        bus_if.w_in = all_w(1);
        spikes(2);
        handoff(1'b1);
        read_lane(0, 2, "inflight_l0");
        read_lane(63, 2, "inflight_l63");
        handoff(1'b0);
        read_lane(0, 0, "cleared_l0");
        read_lane(17, 0, "cleared_l17");

        // Overflow on lane 0.
        bus_if.w_in = one_w(0, 7);
        spikes(600);
        cycle();
        handoff(1'b1);
`ifdef SPIKE_ACC_SATURATE_EN
        read_lane(0, 2047, "overflow_l0");
`else
        read_lane(0, 104, "overflow_l0");
`endif
        read_lane(1, 0, "overflow_l1");

        // Read during snapshot: shadow 10, live 20 on lane 2.
        bus_if.w_in = one_w(2, 5);
        spikes(2);
        cycle();
        handoff(1'b0);
        spikes(2);
        cycle();
        bus_if.ac_sel       = 6'd2;
        bus_if.cntrl_ac_oen = 1'b1;
        cycle();
        check("rds_old", int'($signed(bus_if.ac_out)), 10);
        bus_if.cntrl_ac_oen = 1'b0;
        cycle();
        check("rds_new", int'($signed(bus_if.ac_out)), 20);
        handoff(1'b1);

        // Reset in the middle of accumulation, with a spike still arriving.
        bus_if.w_in = all_w(1);
        spikes(2);
        bus_if.spk_in    = 1'b1;
        bus_if.spk_valid = 1'b1;
        reset = 1'b1;
        cycle();
        check("midrst_out", int'($signed(bus_if.ac_out)), 0);
        check("midrst_valid", int'(bus_if.ac_snap_valid), 0);
        reset = 1'b0;
        idle_inputs();
        cycle();
        handoff(1'b0);
        read_lane(0, 0, "midrst_l0");
        read_lane(40, 0, "midrst_l40");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_NEU; i++)
                bus_if.w_in[i*W_W +: W_W] = W_W'($urandom);
            bus_if.spk_in         = ($urandom_range(0, 3) != 0);
            bus_if.spk_valid      = ($urandom_range(0, 4) != 0);
            bus_if.cntrl_ac_oen   = ($urandom_range(0, 15) == 0);
            bus_if.cntrl_ac_reset = ($urandom_range(0, 15) == 0);
            bus_if.ac_sel         = SEL_W'($urandom);
            reset                 = ($urandom_range(0, 127) == 0);
            cycle();
        end
        reset = 1'b0;
        idle_inputs();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
